// File: rtl/fan_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// fan_pwm_ramp_ctrl
//
// Board fan controller. Converts the 4-bit fan switch setting into a PWM fan
// drive whose period is 15*StepCycles clocks (~25 kHz at 50 MHz). A fan that
// is stopped is first kick-started at 100 % duty for KickPeriods PWM periods.
// After that, the applied duty level walks one step at a time toward the
// requested level, with one step every RampPeriods PWM periods. The level,
// the state and the target are only updated at a period boundary, so a PWM
// period always completes with the duty it started with.
//
// Ports
//   clk_i          in   soc clock
//   rst_ni         in   synchronous active-low reset
//   pwm_setting_i  in   requested level 0..15 (asynchronous board switches)
//   fan_pwm_o      out  registered PWM drive
//   level_o        out  duty level currently applied (0..15)
//   busy_o         out  high while kick-starting or ramping
//   period_tick_o  out  one-cycle pulse on the last cycle of each PWM period
// -----------------------------------------------------------------------------
module fan_pwm_ramp_ctrl #(
    parameter int StepCycles  = 134,
    parameter int RampPeriods = 64,
    parameter int KickPeriods = 500,
    parameter int SyncStages  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] pwm_setting_i,
    output logic       fan_pwm_o,
    output logic [3:0] level_o,
    output logic       busy_o,
    output logic       period_tick_o
);

    localparam int P  = 15 * StepCycles;
    localparam int PW = $clog2(P);
    localparam int TW = PW + 1;
    localparam int KW = $clog2(KickPeriods + 1);
    localparam int RW = $clog2(RampPeriods + 1);

    localparam logic [PW-1:0] PCNT_LAST = PW'(P - 1);
    localparam logic [KW-1:0] KICK_LAST = KW'(KickPeriods - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RampPeriods - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_KICK,
        ST_RAMP,
        ST_STEADY
    } state_t;

    state_t         state;
    logic [3:0]     sync_p [SyncStages];
    logic [3:0]     tgt_s;
    logic [PW-1:0]  pcnt;
    logic [PW-1:0]  pcnt_nxt;
    logic [KW-1:0]  kick_cnt;
    logic [RW-1:0]  ramp_cnt;
    logic [3:0]     lvl_step;
    logic           pwm_d;

    // Duty comparator: high while the period counter is below level*StepCycles.
    // The end levels are forced so that 0 and 15 never produce a stray edge.
    function automatic logic duty_bit(input state_t st, input logic [3:0] lvl,
                                      input logic [PW-1:0] cnt);
        logic [TW-1:0] thr;
        thr = TW'(lvl) * TW'(StepCycles);
        if (st == ST_KICK)
            return 1'b1;
        else if (lvl == 4'd15)
            return 1'b1;
        else if (lvl == 4'd0)
            return 1'b0;
        else
            return ({1'b0, cnt} < thr);
    endfunction

    // One level toward the target, saturating at 0 and 15.
    function automatic logic [3:0] step_toward(input logic [3:0] lvl, input logic [3:0] tgt);
        if ((tgt > lvl) && (lvl != 4'd15))
            return lvl + 4'd1;
        else if ((tgt < lvl) && (lvl != 4'd0))
            return lvl - 4'd1;
        else
            return lvl;
    endfunction

    // ---- switch synchroniser ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SyncStages; i++)
                sync_p[i] <= '0;
        end else begin
            sync_p[0] <= pwm_setting_i;
            for (int i = 1; i < SyncStages; i++)
                sync_p[i] <= sync_p[i-1];
        end
    end

    // The FSM only looks at this on period_tick_o, which is what latches the
    // target once per period.
    assign tgt_s = sync_p[SyncStages-1];

    // ---- PWM period counter ----
    assign pcnt_nxt = (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pcnt          <= '0;
            period_tick_o <= 1'b0;
        end else begin
            pcnt          <= pcnt_nxt;
            period_tick_o <= (pcnt_nxt == PCNT_LAST);
        end
    end

    // ---- duty generation, one cycle behind the counter ----
    assign pwm_d = duty_bit(state, level_o, pcnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            fan_pwm_o <= 1'b0;
        else
            fan_pwm_o <= pwm_d;
    end

    // ---- kick / ramp state machine, advanced once per PWM period ----
    assign lvl_step = step_toward(level_o, tgt_s);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_OFF;
            level_o  <= 4'd0;
            busy_o   <= 1'b0;
            kick_cnt <= '0;
            ramp_cnt <= '0;
        end else if (period_tick_o) begin
            case (state)
                ST_OFF: begin
                    if (tgt_s != 4'd0) begin
                        state    <= ST_KICK;
                        busy_o   <= 1'b1;
                        kick_cnt <= '0;
                    end
                end

                ST_KICK: begin
                    if (tgt_s == 4'd0) begin
                        state    <= ST_OFF;
                        busy_o   <= 1'b0;
                        level_o  <= 4'd0;
                        kick_cnt <= '0;
                    end else if (kick_cnt == KICK_LAST) begin
                        kick_cnt <= '0;
                        ramp_cnt <= '0;
                        level_o  <= 4'd1;
                        if (tgt_s == 4'd1) begin
                            state  <= ST_STEADY;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= ST_RAMP;
                            busy_o <= 1'b1;
                        end
                    end else begin
                        kick_cnt <= kick_cnt + 1'b1;
                    end
                end

                // The direction is re-evaluated at every step and the step
                // timer keeps running across target changes. Ramping down to
                // zero ends in OFF, so a later nonzero setting kicks again.
                ST_RAMP: begin
                    if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt <= '0;
                        level_o  <= lvl_step;
                        if (lvl_step == tgt_s) begin
                            state  <= (tgt_s == 4'd0) ? ST_OFF : ST_STEADY;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end

                ST_STEADY: begin
                    if (tgt_s != level_o) begin
                        state    <= ST_RAMP;
                        busy_o   <= 1'b1;
                        ramp_cnt <= '0;
                    end
                end

                default: begin
                    state   <= ST_OFF;
                    busy_o  <= 1'b0;
                    level_o <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fan_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_pwm_ramp_ctrl
//
// Directed bench for fan_pwm_ramp_ctrl with StepCycles=4, RampPeriods=2,
// KickPeriods=3 (PWM period 60 clocks). Each table row applies a setting at
// a period boundary and runs a number of whole periods. It then checks the
// level and busy flags at the boundary it lands on. It also checks the exact
// fan_pwm_o waveform of the last period, where sample i reflects pcnt i-1, and
// checks that period_tick_o is placement-correct in every period. Hand
// sequences cover mid-period setting changes, short glitches, and a reset
// taken in the middle of a ramp.
// -----------------------------------------------------------------------------
module tb_fan_pwm_ramp_ctrl;

    localparam int PER = 60;

    logic       clk;
    logic       rst_ni;
    logic [3:0] setting;
    logic       fan_pwm;
    logic [3:0] level;
    logic       busy;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    fan_pwm_ramp_ctrl #(
        .StepCycles (4),
        .RampPeriods(2),
        .KickPeriods(3),
        .SyncStages (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pwm_setting_i(setting),
        .fan_pwm_o    (fan_pwm),
        .level_o      (level),
        .busy_o       (busy),
        .period_tick_o(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         pre;      // hand sequence to run before this row (0 = none)
        logic [3:0] setting;
        int         nper;
        logic [3:0] lvl;
        logic       busy;
        int         hi;       // high cycles expected in the last period run
    } vec_t;

    vec_t vecs [29];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] exp_pat(input int hi);
        logic [59:0] r;
        r = '0;
        for (int i = 0; i < PER; i++)
            if (i < hi) r[i] = 1'b1;
        return r;
    endfunction

    // Runs one PWM period from an aligned boundary. The setting can be changed
    // after sample at1 and again after sample at2 (use -1 for no change).
    task automatic run_period(input int at1, input logic [3:0] v1,
                              input int at2, input logic [3:0] v2,
                              output logic [59:0] pat, output int tick_err);
        pat      = '0;
        tick_err = 0;
        for (int i = 1; i <= PER; i++) begin
            @(posedge clk);
            @(negedge clk);
            pat[i-1] = fan_pwm;
            if (tick !== (i == PER - 1)) tick_err++;
            if (i == at1) setting = v1;
            if (i == at2) setting = v2;
        end
    endtask

    task automatic hand_seq1();
        logic [59:0] pat;
        int te;
        // 4 -> 9 -> 4 inside one period: no effect on this or next period
        run_period(20, 4'd9, 40, 4'd4, pat, te);
        chk("toggle pattern", pat, exp_pat(16));
        chk("toggle tick", te, 0);
        chk("toggle level", level, 4'd4);
        chk("toggle busy", busy, 1'b0);
        // one-cycle glitch well before the tick
        run_period(50, 4'd9, 51, 4'd4, pat, te);
        chk("glitch pattern", pat, exp_pat(16));
        chk("glitch tick", te, 0);
        chk("glitch level", level, 4'd4);
        chk("glitch busy", busy, 1'b0);
        // real change mid-period: duty stays, ramp starts at the boundary
        run_period(30, 4'd9, -1, 4'd0, pat, te);
        chk("midchg pattern", pat, exp_pat(16));
        chk("midchg tick", te, 0);
        chk("midchg level", level, 4'd4);
        chk("midchg busy", busy, 1'b1);
    endtask

    task automatic hand_seq2();
        setting = 4'd6;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("prerst pwm", fan_pwm, 1'b1);
        chk("prerst level", level, 4'd6);
        chk("prerst busy", busy, 1'b1);
        rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst pwm", fan_pwm, 1'b0);
        chk("midrst level", level, 4'd0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst tick", tick, 1'b0);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [59:0] pat;
        int te;
        int terr;

        vecs[0]  = '{0, 4'd0,  10, 4'd0,  1'b0, 0};
        vecs[1]  = '{0, 4'd15, 1,  4'd0,  1'b1, 0};
        vecs[2]  = '{0, 4'd15, 1,  4'd0,  1'b1, 60};
        vecs[3]  = '{0, 4'd15, 2,  4'd1,  1'b1, 60};
        vecs[4]  = '{0, 4'd15, 1,  4'd1,  1'b1, 4};
        vecs[5]  = '{0, 4'd15, 1,  4'd2,  1'b1, 4};
        vecs[6]  = '{0, 4'd15, 26, 4'd15, 1'b0, 56};
        vecs[7]  = '{0, 4'd15, 1,  4'd15, 1'b0, 60};
        vecs[8]  = '{0, 4'd8,  1,  4'd15, 1'b1, 60};
        vecs[9]  = '{0, 4'd8,  14, 4'd8,  1'b0, 36};
        vecs[10] = '{0, 4'd8,  1,  4'd8,  1'b0, 32};
        vecs[11] = '{0, 4'd15, 15, 4'd15, 1'b0, 56};
        vecs[12] = '{0, 4'd0,  1,  4'd15, 1'b1, 60};
        vecs[13] = '{0, 4'd0,  30, 4'd0,  1'b0, 4};
        vecs[14] = '{0, 4'd0,  3,  4'd0,  1'b0, 0};
        vecs[15] = '{0, 4'd4,  10, 4'd4,  1'b0, 12};
        vecs[16] = '{0, 4'd4,  1,  4'd4,  1'b0, 16};
        vecs[17] = '{1, 4'd9,  2,  4'd5,  1'b1, 16};
        vecs[18] = '{0, 4'd9,  8,  4'd9,  1'b0, 32};
        vecs[19] = '{0, 4'd12, 3,  4'd10, 1'b1, 36};
        vecs[20] = '{0, 4'd8,  2,  4'd9,  1'b1, 40};
        vecs[21] = '{0, 4'd8,  2,  4'd8,  1'b0, 36};
        vecs[22] = '{0, 4'd0,  5,  4'd6,  1'b1, 28};
        vecs[23] = '{0, 4'd3,  6,  4'd3,  1'b0, 16};
        vecs[24] = '{0, 4'd10, 7,  4'd6,  1'b1, 20};
        vecs[25] = '{2, 4'd6,  1,  4'd0,  1'b1, 0};
        vecs[26] = '{0, 4'd6,  1,  4'd0,  1'b1, 60};
        vecs[27] = '{0, 4'd6,  2,  4'd1,  1'b1, 60};
        vecs[28] = '{0, 4'd6,  10, 4'd6,  1'b0, 20};

        rst_ni  = 1'b0;
        setting = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pwm", fan_pwm, 1'b0);
        chk("reset level", level, 4'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset tick", tick, 1'b0);
        rst_ni = 1'b1;

        for (int k = 0; k < 29; k++) begin
            if (vecs[k].pre == 1) hand_seq1();
            if (vecs[k].pre == 2) hand_seq2();
            setting = vecs[k].setting;
            terr = 0;
            for (int p = 0; p < vecs[k].nper; p++) begin
                run_period(-1, 4'd0, -1, 4'd0, pat, te);
                terr += te;
            end
            chk($sformatf("row%0d level", k), level, vecs[k].lvl);
            chk($sformatf("row%0d busy", k), busy, vecs[k].busy);
            chk($sformatf("row%0d pwm pattern", k), pat, exp_pat(vecs[k].hi));
            chk($sformatf("row%0d tick", k), terr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
